// File: rtl/window_scanner_pkg.sv
// rtl/window_scanner_pkg.sv - shared sizes and FSM encoding for the window scanner
package window_scanner_pkg;
  localparam int IMG_W     = 416;
  localparam int PIX_W     = 8;
  localparam int PAD_W     = IMG_W + 2;
  localparam int WIN_BYTES = 27;
  localparam int ROW_BITS  = PAD_W * PIX_W;
  localparam int WIN_BITS  = WIN_BYTES * PIX_W;
  localparam int SLICE_BITS = 9 * PIX_W;
  localparam int COL_W     = 9;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SCAN = 1'b1
  } state_t;
endpackage

// File: rtl/window_scanner_win_slice3x3.sv
// rtl/window_scanner_win_slice3x3.sv - combinational 3x3 pixel slice of one channel at a column
module win_slice3x3
  import window_scanner_pkg::*;
(
  input  logic [ROW_BITS-1:0]   row0,
  input  logic [ROW_BITS-1:0]   row1,
  input  logic [ROW_BITS-1:0]   row2,
  input  logic [COL_W-1:0]      col,
  output logic [SLICE_BITS-1:0] slice
);

  logic [ROW_BITS-1:0] sh0;
  logic [ROW_BITS-1:0] sh1;
  logic [ROW_BITS-1:0] sh2;

  // Shifting the row down by col pixels leaves pixels col..col+2 in the low bytes.
  always_comb begin
    sh0   = row0 >> (32'(col) * PIX_W);
    sh1   = row1 >> (32'(col) * PIX_W);
    sh2   = row2 >> (32'(col) * PIX_W);
    slice = {sh2[3*PIX_W-1:0], sh1[3*PIX_W-1:0], sh0[3*PIX_W-1:0]};
  end

endmodule

// File: rtl/window_scanner.sv
// rtl/window_scanner.sv - snapshots a padded row set and streams its 3x3x3 windows
module window_scanner
  import window_scanner_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                row_valid,
  output logic                row_ready,
  input  logic [ROW_BITS-1:0] R_row0,
  input  logic [ROW_BITS-1:0] R_row1,
  input  logic [ROW_BITS-1:0] R_row2,
  input  logic [ROW_BITS-1:0] G_row0,
  input  logic [ROW_BITS-1:0] G_row1,
  input  logic [ROW_BITS-1:0] G_row2,
  input  logic [ROW_BITS-1:0] B_row0,
  input  logic [ROW_BITS-1:0] B_row1,
  input  logic [ROW_BITS-1:0] B_row2,
  output logic                win_valid,
  input  logic                win_ready,
  output logic [WIN_BITS-1:0] win_data,
  output logic [COL_W-1:0]    win_col,
  output logic                win_last
);

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - 1);

  state_t              state;
  logic [ROW_BITS-1:0] snap   [9];
  logic [ROW_BITS-1:0] row_in [9];
  logic [ROW_BITS-1:0] src    [9];
  logic [COL_W-1:0]    slice_col;
  logic [WIN_BITS-1:0] next_win;

  // While idle the slicers look at the incoming rows at column 0, so the first
  // window is registered on the same edge that takes the snapshot.
  always_comb begin
    row_in[0] = R_row0;
    row_in[1] = R_row1;
    row_in[2] = R_row2;
    row_in[3] = G_row0;
    row_in[4] = G_row1;
    row_in[5] = G_row2;
    row_in[6] = B_row0;
    row_in[7] = B_row1;
    row_in[8] = B_row2;
    for (int i = 0; i < 9; i++) begin
      src[i] = (state == S_IDLE) ? row_in[i] : snap[i];
    end
    slice_col = (state == S_IDLE) ? '0 : win_col + 1'b1;
  end

  for (genvar ch = 0; ch < 3; ch++) begin : g_slice
    win_slice3x3 u_slice (
      .row0  (src[ch*3]),
      .row1  (src[ch*3+1]),
      .row2  (src[ch*3+2]),
      .col   (slice_col),
      .slice (next_win[ch*SLICE_BITS +: SLICE_BITS])
    );
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      row_ready <= 1'b0;
      win_valid <= 1'b0;
      win_data  <= '0;
      win_col   <= '0;
      win_last  <= 1'b0;
      for (int i = 0; i < 9; i++) snap[i] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          row_ready <= 1'b1;
          if (row_valid && row_ready) begin
            for (int i = 0; i < 9; i++) snap[i] <= row_in[i];
            win_data  <= next_win;
            win_col   <= '0;
            win_last  <= (LAST_COL == '0);
            win_valid <= 1'b1;
            row_ready <= 1'b0;
            state     <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (win_valid && win_ready) begin
            if (win_col == LAST_COL) begin
              win_valid <= 1'b0;
              win_last  <= 1'b0;
              row_ready <= 1'b1;
              state     <= S_IDLE;
            end else begin
              win_col  <= win_col + 1'b1;
              win_data <= next_win;
              win_last <= (win_col == LAST_COL - 1'b1);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_window_scanner.sv
// tb/tb_window_scanner.sv - scoreboard bench for window_scanner
module tb_window_scanner;
  import window_scanner_pkg::*;

  typedef struct {
    logic [WIN_BITS-1:0] data;
    logic [COL_W-1:0]    col;
    logic                last;
    int                  tag;
  } exp_t;

  logic                clk = 1'b0;
  logic                reset;
  logic                row_valid;
  logic                row_ready;
  logic [ROW_BITS-1:0] rows [9];
  logic                win_valid;
  logic                win_ready;
  logic [WIN_BITS-1:0] win_data;
  logic [COL_W-1:0]    win_col;
  logic                win_last;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   xfers = 0;

  always #5 clk = ~clk;

  window_scanner dut (
    .clk       (clk),
    .reset     (reset),
    .row_valid (row_valid),
    .row_ready (row_ready),
    .R_row0    (rows[0]),
    .R_row1    (rows[1]),
    .R_row2    (rows[2]),
    .G_row0    (rows[3]),
    .G_row1    (rows[4]),
    .G_row2    (rows[5]),
    .B_row0    (rows[6]),
    .B_row1    (rows[7]),
    .B_row2    (rows[8]),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .win_data  (win_data),
    .win_col   (win_col),
    .win_last  (win_last)
  );

  task automatic chk(input string name, input logic [WIN_BITS-1:0] act, input logic [WIN_BITS-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fill(input int mode);
    int v;
    for (int ch = 0; ch < 3; ch++)
      for (int r = 0; r < 3; r++)
        for (int p = 0; p < PAD_W; p++) begin
          case (mode)
            0:       v = (ch == 0 && r == 0) ? p % 256 : 0;
            1:       v = 16 * ch + r + 1;
            2:       v = (p * 7 + ch * 31 + r * 13) % 256;
            3:       v = 255 - ((p * 7 + ch * 31 + r * 13) % 256);
            default: v = (p * 3 + ch * 5 + r * 11 + 100) % 256;
          endcase
          rows[ch*3+r][p*PIX_W +: PIX_W] = 8'(v);
        end
  endtask

  function automatic logic [WIN_BITS-1:0] exp_data(input int c);
    logic [WIN_BITS-1:0] d;
    d = '0;
    for (int ch = 0; ch < 3; ch++)
      for (int r = 0; r < 3; r++)
        for (int k = 0; k < 3; k++)
          d[(ch*9 + r*3 + k)*PIX_W +: PIX_W] = rows[ch*3+r][(c+k)*PIX_W +: PIX_W];
    return d;
  endfunction

  task automatic push_set(input int tag);
    exp_t e;
    for (int c = 0; c < IMG_W; c++) begin
      e.data = exp_data(c);
      e.col  = COL_W'(c);
      e.last = (c == IMG_W - 1);
      e.tag  = tag;
      q.push_back(e);
    end
  endtask

  // Monitor: every handshake pops one expected window.
  always @(negedge clk) begin
    exp_t e;
    if (reset && win_valid && win_ready) begin
      xfers++;
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_window: got col %0d expected none", win_col);
      end else begin
        e = q.pop_front();
        chk("win_col", WIN_BITS'(win_col), WIN_BITS'(e.col));
        chk("win_data", win_data, e.data);
        chk("win_last", WIN_BITS'(win_last), WIN_BITS'(e.last));
        if (e.tag == 0 && e.col == 0)   chk("ramp_col0", WIN_BITS'(win_data[23:0]), WIN_BITS'(24'h020100));
        if (e.tag == 0 && e.col == 415) chk("ramp_col415", WIN_BITS'(win_data[23:0]), WIN_BITS'(24'hA1A09F));
        if (e.tag == 1 && e.col == 0) begin
          chk("order_b0", WIN_BITS'(win_data[7:0]), WIN_BITS'(8'h01));
          chk("order_b13", WIN_BITS'(win_data[13*8 +: 8]), WIN_BITS'(8'h12));
          chk("order_b26", WIN_BITS'(win_data[26*8 +: 8]), WIN_BITS'(8'h23));
        end
      end
    end
  end

  task automatic send_rows(input int mode);
    bit ok;
    ok = 0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(posedge clk); #1;
      if (row_ready) ok = 1;
    end
    if (!ok) chk("row_ready_timeout", 0, 1);
    fill(mode);
    push_set(mode);
    row_valid = 1'b1;
    @(posedge clk); #1;
    row_valid = 1'b0;
  endtask

  task automatic wait_col(input int c);
    bit ok;
    ok = 0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(posedge clk); #1;
      if (win_valid && win_col == COL_W'(c)) ok = 1;
    end
    if (!ok) chk("wait_col_timeout", 0, WIN_BITS'(c));
  endtask

  task automatic wait_qsize(input int n);
    bit ok;
    ok = 0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk); #1;
      if (q.size() == n) ok = 1;
    end
    if (!ok) chk("queue_drain_timeout", WIN_BITS'(q.size()), WIN_BITS'(n));
  endtask

  task automatic wait_done(input int n_exp);
    wait_qsize(0);
    @(negedge clk);
    chk("idle_row_ready", WIN_BITS'(row_ready), 1);
    chk("idle_win_valid", WIN_BITS'(win_valid), 0);
    chk("transfer_count", WIN_BITS'(xfers), WIN_BITS'(n_exp));
  endtask

  initial begin
    reset     = 1'b0;
    row_valid = 1'b1;
    win_ready = 1'b1;
    fill(1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_row_ready", WIN_BITS'(row_ready), 0);
      chk("rst_win_valid", WIN_BITS'(win_valid), 0);
    end
    chk("rst_win_data", win_data, 0);
    chk("rst_win_col", WIN_BITS'(win_col), 0);
    chk("rst_win_last", WIN_BITS'(win_last), 0);
    row_valid = 1'b0;
    reset     = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_row_ready", WIN_BITS'(row_ready), 1);
    chk("post_rst_win_valid", WIN_BITS'(win_valid), 0);

    // Ramp on R row 0.
    xfers = 0;
    send_rows(0);
    wait_done(IMG_W);

    // Channel/row ordering.
    xfers = 0;
    send_rows(1);
    wait_done(IMG_W);

    // Backpressure at column 10, then ignored row input at column 100.
    xfers = 0;
    send_rows(2);
    wait_col(10);
    win_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_col", WIN_BITS'(win_col), 10);
      chk("bp_data", win_data, exp_data(10));
    end
    @(posedge clk); #1;
    win_ready = 1'b1;
    wait_col(100);
    fill(3);
    row_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("scan_row_ready", WIN_BITS'(row_ready), 0);
    end
    @(posedge clk); #1;
    row_valid = 1'b0;
    wait_done(IMG_W);

    // Reset in the middle of a scan.
    xfers = 0;
    send_rows(4);
    wait_col(200);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("midrst_win_valid", WIN_BITS'(win_valid), 0);
    chk("midrst_win_col", WIN_BITS'(win_col), 0);
    chk("midrst_win_data", win_data, 0);
    chk("midrst_win_last", WIN_BITS'(win_last), 0);
    chk("midrst_row_ready", WIN_BITS'(row_ready), 0);
    q.delete();
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst_release_ready", WIN_BITS'(row_ready), 1);
    xfers = 0;
    send_rows(1);
    wait_done(IMG_W);

    // row_valid held through the final transfer: taken in the following idle cycle.
    xfers = 0;
    send_rows(4);
    fill(2);
    push_set(2);
    row_valid = 1'b1;
    wait_qsize(IMG_W);
    chk("final_row_ready", WIN_BITS'(row_ready), 0);
    chk("final_win_last", WIN_BITS'(win_last), 1);
    @(negedge clk);
    chk("gap_win_valid", WIN_BITS'(win_valid), 0);
    chk("gap_row_ready", WIN_BITS'(row_ready), 1);
    @(posedge clk); #1;
    row_valid = 1'b0;
    @(negedge clk);
    chk("next_win_valid", WIN_BITS'(win_valid), 1);
    chk("next_win_col", WIN_BITS'(win_col), 0);
    wait_done(2 * IMG_W);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/window_scanner.md
# window_scanner

Downstream neighbour of the padding stage. Accepts one set of nine zero-padded rows (R/G/B × rows 0..2, each IMG_W+2 pixels), snapshots them, then streams the IMG_W 3×3×3 windows left to right over a valid/ready handshake to the convolution engine. Frees the padding stage to prepare the next row set while the current one is scanned.

## Interface
- IMG_W, 416, unpadded row width in pixels
- PIX_W, 8, bits per pixel
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset
- row_valid  input  1  padded row set on R/G/B_row* is valid
- row_ready  output  1  scanner idle, accepts a row set this cycle
- R_row0, R_row1, R_row2  input  (IMG_W+2)*PIX_W each (3344)  padded red rows, top to bottom
- G_row0, G_row1, G_row2  input  (IMG_W+2)*PIX_W each  padded green rows
- B_row0, B_row1, B_row2  input  (IMG_W+2)*PIX_W each  padded blue rows
- win_valid  output  1  win_data holds a valid window
- win_ready  input  1  consumer accepts window
- win_data  output  27*PIX_W (216)  3×3×3 window
- win_col  output  9  column index of current window, 0..IMG_W-1
- win_last  output  1  current window is column IMG_W-1

## Operation
- Pixel p of a row occupies bits [p*PIX_W +: PIX_W]; pixel 0 in the LSBs.
- Window at column c uses padded pixels c, c+1, c+2 of every row.
- win_data byte index = ch*9 + r*3 + k (ch R=0,G=1,B=2; r row 0..2; k 0..2); byte i at bits [i*PIX_W +: PIX_W].
- FSM: IDLE, SCAN.
  - IDLE: row_ready=1. row_valid & row_ready → snapshot all nine rows, col←0, go SCAN.
  - SCAN: row_ready=0; row_valid ignored. Transfer = win_valid & win_ready. On transfer with col<IMG_W-1: col←col+1. On transfer with col=IMG_W-1: win_valid←0, go IDLE.
- Held outputs: while win_valid & !win_ready, win_data/win_col/win_last stay constant.
- win_last = win_valid & (win_col = IMG_W-1).
- Row inputs sampled only on the accepting edge; later changes have no effect.

## Timing
- Reset values (reset=0 at edge): state IDLE, row_ready 0, win_valid 0, win_data 0, win_col 0, win_last 0, snapshot 0.
- row_ready is registered: 1 from the first cycle after reset deasserts.
- Latency: row accepted at edge N → win_valid=1, win_col=0 after edge N (visible cycle N+1).
- Throughput: one window per cycle with win_ready held high; IMG_W windows, then one IDLE cycle (row_ready=1) before the next set can be accepted: IMG_W+1 cycles per row set minimum.
- win_valid never deasserts mid-row without a transfer of win_last.
- Reset mid-SCAN: next edge returns all outputs to reset values; snapshot discarded; no partial row resumed.
- Simultaneous row_valid and final transfer: row_valid not accepted that cycle (row_ready=0); accepted in the following IDLE cycle.

## Structure
- Shared package: IMG_W, PIX_W, PAD_W=IMG_W+2, WIN_BYTES=27, FSM state encoding.
- Sub-module win_slice3x3: combinational extraction of a 3×3 slice from three padded rows of one channel at column c; instantiated three times (R,G,B).
- Column counter 9 bits; output window registered.

## Test plan
- Reset: hold reset=0 three cycles with row_valid=1 → all outputs 0, nothing accepted; first cycle after release row_ready=1.
- Ramp: R_row0 pixel p = p mod 256, others 0, win_ready=1 → windows col 0..415 consecutive; col 0 R-row0 bytes 0,1,2; col 415 bytes 159,160,161; win_last only at col 415; row_ready=1 the next cycle.
- Ordering: every pixel of (ch,r) = 16*ch + r + 1 → each window's byte ch*9+r*3+k equals 16*ch+r+1 (e.g. byte 0=0x01, byte 26=0x23).
- Backpressure: win_ready=0 for 5 cycles while win_col=10 → win_data/win_col stable at 10; then resumes 11 with no skipped or duplicated columns, 416 transfers total.
- Ignored input: change row data and pulse row_valid during SCAN → windows still match the snapshot; row_ready stays 0.
- Reset mid-scan at win_col=200 → win_valid 0 after next edge; after release, a fresh row set scans from col 0.
